// File: rtl/prg_ram_cache_if.sv
// sdram_bus: one SDRAM controller port; the controller modport issues requests, the memory modport answers.
interface sdram_bus #(parameter int AW = 22);
  logic          req;
  logic          we;
  logic [AW-1:0] address;
  logic [15:0]   data_write;
  logic [1:0]    wm;
  logic [15:0]   data_read;
  logic          ack;
  modport controller (output req, we, address, data_write, wm, input data_read, ack);
  modport memory (input req, we, address, data_write, wm, output data_read, ack);
endinterface

// File: rtl/prg_ram_cache.sv
// prg_ram_cache: direct-mapped write-through word cache between async CPU strobes and one SDRAM port.
module prg_ram_cache #(
  parameter int ADDR_BITS   = 23,
  parameter int LINES       = 4,
  parameter int SYNC_STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_bus.controller         ram,
  input  logic                 oe,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           data_in,
  input  logic                 invalidate,
  output logic [7:0]           data_out,
  output logic                 busy
);
  localparam int IW = $clog2(LINES);
  localparam int WW = ADDR_BITS - 1;
  localparam int TW = WW - IW;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_oe_s, r_we_s;
  logic [LINES-1:0] r_valid;
  logic [TW-1:0] r_tag [LINES];
  logic [15:0] r_data [LINES];
  logic r_pw, r_pr;
  logic [ADDR_BITS-1:0] r_pw_addr;
  logic [WW-1:0] r_pr_word;
  logic [7:0] r_pw_data;
  logic r_req, r_ram_we;
  logic [WW-1:0] r_address;
  logic [15:0] r_wdata, w_line;
  logic [1:0] r_wm;
  logic w_oe_ev, w_we_ev, w_idle, w_wr_go, w_rd_try, w_rd_go, w_wr_hit, w_rd_hit, w_fill;
  logic [ADDR_BITS-1:0] w_wr_addr;
  logic [WW-1:0] w_wr_word, w_rd_word;
  logic [7:0] w_wr_data;
  // An event needs two consecutive high samples after a low one, which rejects one-sample glitches.
  assign w_oe_ev   = r_oe_s[SYNC_STAGES-1 -: 3] == 3'b011;
  assign w_we_ev   = r_we_s[SYNC_STAGES-1 -: 3] == 3'b011;
  assign w_idle    = r_state == IDLE;
  assign w_wr_go   = w_idle && (w_we_ev || r_pw);
  assign w_wr_addr = w_we_ev ? addr : r_pw_addr;
  assign w_wr_data = w_we_ev ? data_in : r_pw_data;
  assign w_wr_word = w_wr_addr[ADDR_BITS-1:1];
  assign w_rd_try  = w_idle && !w_wr_go && (w_oe_ev || r_pr);
  assign w_rd_word = w_oe_ev ? addr[ADDR_BITS-1:1] : r_pr_word;
  assign w_wr_hit  = r_valid[w_wr_word[IW-1:0]] && r_tag[w_wr_word[IW-1:0]] == w_wr_word[WW-1:IW];
  assign w_rd_hit  = r_valid[w_rd_word[IW-1:0]] && r_tag[w_rd_word[IW-1:0]] == w_rd_word[WW-1:IW];
  assign w_rd_go   = w_rd_try && !w_rd_hit;
  assign w_fill    = r_state == RD_WAIT && ram.ack;
  assign w_line    = r_data[addr[IW:1]];
  assign data_out  = addr[0] ? w_line[15:8] : w_line[7:0];
  assign busy      = !w_idle || r_pw || r_pr;
  assign ram.req        = r_req;
  assign ram.we         = r_ram_we;
  assign ram.address    = r_address;
  assign ram.data_write = r_wdata;
  assign ram.wm         = r_wm;
  always_comb begin
    w_next = r_state;
    w_next = w_idle ? (w_wr_go ? WR_WAIT : w_rd_go ? RD_WAIT : IDLE) : (ram.ack ? IDLE : r_state);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_oe_s    <= '0;
      r_we_s    <= '0;
      r_valid   <= '0;
      r_pw      <= 1'b0;
      r_pr      <= 1'b0;
      r_pw_addr <= '0;
      r_pr_word <= '0;
      r_pw_data <= '0;
      r_req     <= 1'b0;
      r_ram_we  <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
      r_wm      <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_oe_s  <= {r_oe_s[SYNC_STAGES-2:0], oe};
      r_we_s  <= {r_we_s[SYNC_STAGES-2:0], we};
      r_req   <= w_wr_go || w_rd_go;
      if (w_wr_go) begin
        r_ram_we  <= 1'b1;
        r_address <= w_wr_word;
        r_wdata   <= {w_wr_data, w_wr_data};
        r_wm      <= w_wr_addr[0] ? 2'b01 : 2'b10;
      end else if (w_rd_go) begin
        r_ram_we  <= 1'b0;
        r_address <= w_rd_word;
      end
      if (w_we_ev && !w_idle) begin
        r_pw      <= 1'b1;
        r_pw_addr <= addr;
        r_pw_data <= data_in;
      end else if (w_wr_go) r_pw <= 1'b0;
      if (w_oe_ev && !w_rd_try) begin
        r_pr      <= 1'b1;
        r_pr_word <= addr[ADDR_BITS-1:1];
      end else if (w_rd_try) r_pr <= 1'b0;
      if (w_wr_go && w_wr_hit) begin
        if (w_wr_addr[0]) r_data[w_wr_word[IW-1:0]][15:8] <= w_wr_data;
        else r_data[w_wr_word[IW-1:0]][7:0] <= w_wr_data;
      end
      if (w_fill) begin
        r_data[r_address[IW-1:0]]  <= ram.data_read;
        r_tag[r_address[IW-1:0]]   <= r_address[WW-1:IW];
        r_valid[r_address[IW-1:0]] <= 1'b1;
      end
      // Applied last so an invalidate beats a coincident fill.
      if (invalidate) r_valid <= '0;
    end
  end
endmodule
